// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared palette entry type and screen constants for the sprite renderer
package sprite_pkg;

   localparam int COLOR_W  = 4;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } pal_entry_t;

endpackage

// File: rtl/palettized_anim_sprite_if.sv
// rtl/palettized_anim_sprite_if.sv - video timing in, sprite ROM port and colour out
interface palettized_anim_sprite_if #(
   parameter int ADDR_W   = 14,
   parameter int IDX_BITS = 4
);
   logic [9:0]          DrawX;
   logic [9:0]          DrawY;
   logic                blank;
   logic [ADDR_W-1:0]   rom_address;
   logic [IDX_BITS-1:0] rom_q;
   logic [3:0]          red;
   logic [3:0]          green;
   logic [3:0]          blue;
   logic                hit;

   // sprite renderer side
   modport master (
      input  DrawX, DrawY, blank, rom_q,
      output rom_address, red, green, blue, hit
   );

   // VGA controller / ROM / colour mapper side
   modport slave (
      output DrawX, DrawY, blank, rom_q,
      input  rom_address, red, green, blue, hit
   );
endinterface

// File: rtl/sprite_palette.sv
// rtl/sprite_palette.sv - combinational palette LUT, index to RGB entry
module sprite_palette
   import sprite_pkg::*;
#(
   parameter int IDX_BITS = 4
) (
   input  logic [IDX_BITS-1:0] idx,
   output pal_entry_t          color
);

   // Table contents are regenerated by the palettizer for each sprite.
   always_comb begin
      color = '0;
      case (4'(idx))
         4'h0: color = '{r: 4'h0, g: 4'h0, b: 4'h0};
         4'h1: color = '{r: 4'h1, g: 4'h1, b: 4'h1};
         4'h2: color = '{r: 4'hF, g: 4'h0, b: 4'h0};
         4'h3: color = '{r: 4'h0, g: 4'hF, b: 4'h0};
         4'h4: color = '{r: 4'h0, g: 4'h0, b: 4'hF};
         4'h5: color = '{r: 4'hF, g: 4'h8, b: 4'h0};
         4'h6: color = '{r: 4'h8, g: 4'hF, b: 4'h0};
         4'h7: color = '{r: 4'h0, g: 4'h8, b: 4'hF};
         4'h8: color = '{r: 4'hF, g: 4'hF, b: 4'h0};
         4'h9: color = '{r: 4'hF, g: 4'h0, b: 4'hF};
         4'hA: color = '{r: 4'h0, g: 4'hF, b: 4'hF};
         4'hB: color = '{r: 4'h8, g: 4'h8, b: 4'h8};
         4'hC: color = '{r: 4'h4, g: 4'h4, b: 4'h4};
         4'hD: color = '{r: 4'hC, g: 4'h6, b: 4'h0};
         4'hE: color = '{r: 4'h6, g: 4'hC, b: 4'h0};
         4'hF: color = '{r: 4'hF, g: 4'hF, b: 4'hF};
         default: color = '0;
      endcase
   end

endmodule

// File: rtl/palettized_anim_sprite.sv
// rtl/palettized_anim_sprite.sv - animated, scaled palettized sprite layer with 3-stage pipeline
module palettized_anim_sprite
   import sprite_pkg::*;
#(
   parameter int IMG_W           = 64,
   parameter int IMG_H           = 64,
   parameter int FRAMES          = 4,
   parameter int IDX_BITS        = 4,
   parameter int SCALE_LOG2      = 0,
   parameter int FRAME_PERIOD    = 8,
   parameter int TRANSPARENT_IDX = 0,
   parameter int ADDR_W          = $clog2(FRAMES*IMG_W*IMG_H),
   parameter int FRAME_W         = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic                    vga_clk,
   input  logic                    reset,
   palettized_anim_sprite_if.master vid,
   input  logic [9:0]              pos_x,
   input  logic [9:0]              pos_y,
   input  logic                    anim_en,
   output logic [FRAME_W-1:0]      frame_idx
);

   localparam int PW    = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam int WIN_W = IMG_W << SCALE_LOG2;
   localparam int WIN_H = IMG_H << SCALE_LOG2;

   logic                fs_q, fs_cond, fs, wrap_period;
   logic [9:0]          px, py, eff_px, eff_py;
   logic [PW-1:0]       period_cnt;
   logic [FRAME_W-1:0]  next_frame, eff_frame;
   logic signed [10:0]  rel_x, rel_y;
   logic                in_win;
   logic [ADDR_W-1:0]   addr_full;
   logic                s1_win, s1_blank, s2_win, s2_blank;
   pal_entry_t          pal_color;

   // Frame-start edge, counter wrap, and the FS bypass so (0,0) already sees new position/frame.
   always_comb begin
      fs_cond     = (vid.DrawX == 10'd0) && (vid.DrawY == 10'd0);
      fs          = fs_cond && !fs_q;
      wrap_period = (period_cnt == PW'(FRAME_PERIOD - 1));
      next_frame  = (frame_idx == FRAME_W'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      eff_px      = fs ? pos_x : px;
      eff_py      = fs ? pos_y : py;
      eff_frame   = (fs && anim_en && wrap_period) ? next_frame : frame_idx;
      rel_x       = $signed({1'b0, vid.DrawX}) - $signed({1'b0, eff_px});
      rel_y       = $signed({1'b0, vid.DrawY}) - $signed({1'b0, eff_py});
      in_win      = !rel_x[10] && !rel_y[10]
                    && ({1'b0, rel_x[9:0]} < 11'(WIN_W))
                    && ({1'b0, rel_y[9:0]} < 11'(WIN_H))
                    && (vid.DrawX < 10'(H_ACTIVE))
                    && (vid.DrawY < 10'(V_ACTIVE));
      addr_full   = ADDR_W'(eff_frame) * ADDR_W'(IMG_W * IMG_H)
                    + ADDR_W'(rel_y[9:0] >> SCALE_LOG2) * ADDR_W'(IMG_W)
                    + ADDR_W'(rel_x[9:0] >> SCALE_LOG2);
   end

   // Per-frame state: position latch and animation counters, updated only at frame start.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         fs_q       <= 1'b0;
         px         <= '0;
         py         <= '0;
         period_cnt <= '0;
         frame_idx  <= '0;
      end else begin
         fs_q <= fs_cond;
         if (fs) begin
            px <= pos_x;
            py <= pos_y;
            if (anim_en) begin
               if (wrap_period) begin
                  period_cnt <= '0;
                  frame_idx  <= next_frame;
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end
         end
      end
   end

   // S1/S2: ROM address (held outside the window) and the flags that travel with it.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         vid.rom_address <= '0;
         s1_win          <= 1'b0;
         s1_blank        <= 1'b0;
         s2_win          <= 1'b0;
         s2_blank        <= 1'b0;
      end else begin
         if (in_win) vid.rom_address <= addr_full;
         s1_win   <= in_win;
         s1_blank <= vid.blank;
         s2_win   <= s1_win;
         s2_blank <= s1_blank;
      end
   end

   sprite_palette #(.IDX_BITS(IDX_BITS)) u_palette (
      .idx   (vid.rom_q),
      .color (pal_color)
   );

   // S3: register palette colour for opaque in-window active pixels, black otherwise.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         vid.red   <= '0;
         vid.green <= '0;
         vid.blue  <= '0;
         vid.hit   <= 1'b0;
      end else if (s2_blank && s2_win && (vid.rom_q != IDX_BITS'(TRANSPARENT_IDX))) begin
         vid.red   <= pal_color.r;
         vid.green <= pal_color.g;
         vid.blue  <= pal_color.b;
         vid.hit   <= 1'b1;
      end else begin
         vid.red   <= '0;
         vid.green <= '0;
         vid.blue  <= '0;
         vid.hit   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_palettized_anim_sprite.sv
// tb/tb_palettized_anim_sprite.sv - directed self-checking bench for palettized_anim_sprite
module tb_palettized_anim_sprite;

   logic       vga_clk = 1'b0;
   logic       reset   = 1'b1;
   logic [9:0] draw_x  = 10'd700;
   logic [9:0] draw_y  = 10'd500;
   logic       blank   = 1'b0;
   logic [9:0] pos0_x  = 10'd100;
   logic [9:0] pos0_y  = 10'd50;
   logic       anim0   = 1'b0;
   logic [1:0] frame0, frame1;
   int         checks  = 0;
   int         passes  = 0;
   int         fails   = 0;

   always #5 vga_clk = ~vga_clk;

   palettized_anim_sprite_if #(.ADDR_W(14), .IDX_BITS(4)) if0 ();
   palettized_anim_sprite_if #(.ADDR_W(14), .IDX_BITS(4)) if1 ();

   assign if0.DrawX = draw_x;
   assign if0.DrawY = draw_y;
   assign if0.blank = blank;
   assign if1.DrawX = draw_x;
   assign if1.DrawY = draw_y;
   assign if1.blank = blank;

   // sprite ROM contents: index = low address nibble xor 5 (address 0 -> 5, 5 -> 0, 6 -> 3)
   function automatic logic [3:0] rom_fn(input logic [13:0] a);
      return a[3:0] ^ 4'h5;
   endfunction

   always @(posedge vga_clk) begin
      if0.rom_q <= rom_fn(if0.rom_address);
      if1.rom_q <= rom_fn(if1.rom_address);
   end

   palettized_anim_sprite #(.SCALE_LOG2(0), .FRAME_PERIOD(2)) dut0 (
      .vga_clk (vga_clk), .reset (reset), .vid (if0),
      .pos_x (pos0_x), .pos_y (pos0_y), .anim_en (anim0), .frame_idx (frame0)
   );

   palettized_anim_sprite #(.SCALE_LOG2(1), .FRAME_PERIOD(8)) dut1 (
      .vga_clk (vga_clk), .reset (reset), .vid (if1),
      .pos_x (10'd0), .pos_y (10'd0), .anim_en (1'b0), .frame_idx (frame1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int x, input int y, input logic b);
      draw_x = 10'(x);
      draw_y = 10'(y);
      blank  = b;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic idle();
      step(700, 500, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge vga_clk);
      #1;
      chk("rst_out", {if0.red, if0.green, if0.blue, if0.hit}, 0);
      chk("rst_addr", if0.rom_address, 0);
      chk("rst_frame", frame0, 0);
      reset = 1'b0;
      idle(); idle();

      // scale x2 at (0,0): 2x2 blocks share one source texel
      step(0, 0, 1);     chk("s1_addr_0_0", if1.rom_address, 0);
      step(1, 0, 1);     chk("s1_addr_1_0", if1.rom_address, 0);
      step(0, 1, 1);     chk("s1_addr_0_1", if1.rom_address, 0);
      step(1, 1, 1);     chk("s1_addr_1_1", if1.rom_address, 0);
      step(2, 0, 1);     chk("s1_addr_2_0", if1.rom_address, 1);
      step(127, 127, 1); chk("s1_addr_127", if1.rom_address, 4095);
      step(128, 0, 1);   chk("s1_addr_hold", if1.rom_address, 4095);
      idle();            chk("s1_hit_127", if1.hit, 1);
      idle();            chk("s1_hit_128", if1.hit, 0);

      // unscaled sprite at (100,50)
      step(100, 50, 1);  chk("a_first", if0.rom_address, 0);
      idle(); idle();
      chk("rgb_first", {if0.red, if0.green, if0.blue}, 12'hF80);
      chk("hit_first", if0.hit, 1);
      step(163, 113, 1); chk("a_last", if0.rom_address, 4095);
      step(164, 50, 1);  chk("a_hold", if0.rom_address, 4095);
      idle();            chk("hit_last", if0.hit, 1);
      idle();            chk("out_right", {if0.red, if0.green, if0.blue, if0.hit}, 0);

      // transparent index, then blanked opaque index
      step(105, 50, 1);  chk("a_transp", if0.rom_address, 5);
      idle(); idle();    chk("out_transp", {if0.red, if0.green, if0.blue, if0.hit}, 0);
      step(106, 50, 0);  chk("a_blank", if0.rom_address, 6);
      idle(); idle();    chk("out_blank", {if0.red, if0.green, if0.blue, if0.hit}, 0);

      // position change mid-frame takes effect at the next frame start
      pos0_x = 10'd200;
      step(100, 50, 1); idle(); idle();
      chk("pos_old_cur", if0.hit, 1);
      idle();
      step(0, 0, 1);
      step(100, 50, 1); idle(); idle();
      chk("pos_old_next", if0.hit, 0);
      step(200, 50, 1); chk("a_pos_new", if0.rom_address, 0);
      idle(); idle();
      chk("rgb_pos_new", {if0.red, if0.green, if0.blue, if0.hit}, 13'h1F01);

      // clipping at the screen edges
      pos0_x = 10'd600; pos0_y = 10'd450;
      step(0, 0, 1);
      step(639, 479, 1); chk("a_clip", if0.rom_address, 1895);
      step(640, 479, 1); chk("a_clip_hold", if0.rom_address, 1895);
      idle();            chk("rgb_clip_in", {if0.red, if0.green, if0.blue, if0.hit}, 13'h1E01);
      idle();            chk("clip_x", if0.hit, 0);
      step(639, 480, 1); idle(); idle();
      chk("clip_y", if0.hit, 0);

      // animation: period 2, 4 frames
      pos0_x = 10'd0; pos0_y = 10'd0; anim0 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("anim_frame", frame0, ((k - 1) / 2) % 4);
         step(0, 0, 1);
         chk("anim_fs_addr", if0.rom_address, ((k / 2) % 4) * 4096);
         idle();
      end
      chk("anim_wrap", frame0, 0);

      // anim_en low holds frame and period counter
      anim0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1); idle();
      end
      chk("hold_frame", frame0, 0);
      anim0 = 1'b1;
      step(0, 0, 1); idle();
      chk("hold_period", frame0, 0);
      step(0, 0, 1); idle();
      chk("resume", frame0, 1);

      // reset in the middle of an opaque run
      step(1, 0, 1); step(2, 0, 1); step(3, 0, 1);
      chk("run_opaque", if0.hit, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out", {if0.red, if0.green, if0.blue, if0.hit}, 0);
      chk("mid_rst_addr", if0.rom_address, 0);
      chk("mid_rst_frame", frame0, 0);
      step(4, 0, 1); step(5, 0, 1);
      reset = 1'b0;
      step(6, 0, 1); chk("post_rst_1", if0.hit, 0);
      step(7, 0, 1); chk("post_rst_2", if0.hit, 0);
      step(8, 0, 1);
      chk("post_rst_3", {if0.red, if0.green, if0.blue, if0.hit}, 13'h01E1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
